// File: rtl/buffer_loader_pkg.sv
// Shared definitions for the host-side input buffer loader.
// Command codes, parser states and default field sizes.
package buffer_loader_pkg;

  localparam int DEF_BUFFER_LENGTH = 16;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_COUNT_WIDTH   = 16;

  localparam int ADDR_BYTES  = DEF_BUFFER_LENGTH / 8;
  localparam int COUNT_BYTES = DEF_COUNT_WIDTH / 8;
  localparam int DATA_BYTES  = DEF_DATA_WIDTH / 8;

  typedef enum logic [7:0] {
    CMD_NOP         = 8'h00,
    CMD_BURST_WRITE = 8'h01
  } LoaderCmd;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_PUSH  = 3'd4
  } LoaderState;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/buffer_loader_assembler.sv
// Little-endian byte shift-in register for one multi-byte field.
// Exposes the word including the byte being shifted this cycle.
module byte_assembler #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         last
);

  localparam int N  = W / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  value;
  logic [IW-1:0] idx;

  assign word = (value >> 8) | ({{(W-8){1'b0}}, byte_in} << (W - 8));
  assign last = shift && (idx == IW'(N - 1));

  // shift bytes in LSB first, wrap the index after the final byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      idx   <= '0;
    end else if (shift) begin
      value <= word;
      idx   <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/buffer_loader.sv
// Host byte stream parser that pushes {addr, data} entries
// into the accelerator input buffer FIFO.
module buffer_loader
  import buffer_loader_pkg::*;
#(
  parameter int BUFFER_LENGTH = DEF_BUFFER_LENGTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     buffer_full,
  output logic                     buffer_write_enable,
  output logic [BUFFER_LENGTH-1:0] buffer_write_addr,
  output logic [DATA_WIDTH-1:0]    buffer_write_data,
  output logic                     busy,
  output logic                     protocol_error,
  output logic [COUNT_WIDTH-1:0]   words_written
);

  LoaderState state, state_nxt;

  logic                     ready_en;
  logic                     accept;
  logic                     is_burst;
  logic                     is_nop;
  logic [BUFFER_LENGTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [COUNT_WIDTH-1:0]   remaining;
  logic [COUNT_WIDTH-1:0]   wcount;
  logic                     perr_q;

  logic [BUFFER_LENGTH-1:0] addr_word;
  logic [COUNT_WIDTH-1:0]   count_word;
  logic [DATA_WIDTH-1:0]    data_word;
  logic                     addr_last;
  logic                     count_last;
  logic                     data_last;

  assign accept   = in_valid && in_ready;
  assign is_burst = (in_data == CMD_BURST_WRITE);
  assign is_nop   = (in_data == CMD_NOP);

  byte_assembler #(.W(BUFFER_LENGTH)) u_addr (
    .clk     (clk),
    .reset   (reset),
    .shift   (accept && state == ST_ADDR),
    .byte_in (in_data),
    .word    (addr_word),
    .last    (addr_last)
  );

  byte_assembler #(.W(COUNT_WIDTH)) u_count (
    .clk     (clk),
    .reset   (reset),
    .shift   (accept && state == ST_COUNT),
    .byte_in (in_data),
    .word    (count_word),
    .last    (count_last)
  );

  byte_assembler #(.W(DATA_WIDTH)) u_data (
    .clk     (clk),
    .reset   (reset),
    .shift   (accept && state == ST_DATA),
    .byte_in (in_data),
    .word    (data_word),
    .last    (data_last)
  );

  // parser state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_CMD;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CMD:
        if (accept && is_burst) state_nxt = ST_ADDR;
      ST_ADDR:
        if (addr_last) state_nxt = ST_COUNT;
      ST_COUNT:
        if (count_last)
          state_nxt = (count_word == '0) ? ST_CMD : ST_DATA;
      ST_DATA:
        if (data_last) state_nxt = ST_PUSH;
      ST_PUSH:
        if (buffer_write_enable)
          state_nxt = (remaining == COUNT_WIDTH'(1)) ? ST_CMD : ST_DATA;
      default:
        state_nxt = ST_CMD;
    endcase
  end

  // handshake and status outputs
  always_comb begin
    in_ready            = ready_en && (state != ST_PUSH);
    buffer_write_enable = (state == ST_PUSH) && !buffer_full;
    busy                = (state != ST_CMD);
  end

  // field capture, address walk and push accounting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      remaining <= '0;
      wcount    <= '0;
      perr_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      perr_q   <= accept && (state == ST_CMD) && !is_burst && !is_nop;
      if (addr_last)
        addr_q <= addr_word;
      else if (buffer_write_enable)
        addr_q <= addr_q + 1'b1;
      if (count_last)
        remaining <= count_word;
      else if (buffer_write_enable)
        remaining <= remaining - 1'b1;
      if (data_last)
        data_q <= data_word;
      if (buffer_write_enable)
        wcount <= wcount + 1'b1;
    end
  end

  assign buffer_write_addr = addr_q;
  assign buffer_write_data = data_q;
  assign protocol_error    = perr_q;
  assign words_written     = wcount;

endmodule
